bus_wait_ram: RTL and testbench

//   Parametrised single-port bus RAM with a req/ready handshake and programmable wait states.

---
 rtl/bus_wait_ram_pkg.sv | 15 +
 rtl/bus_wait_ram_if.sv | 25 ++
 rtl/bus_wait_ram_array.sv | 26 ++
 rtl/bus_wait_ram.sv | 117 +++++++++++
 tb/tb_bus_wait_ram.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_wait_ram_pkg.sv
// Shared definitions for the wait-state bus RAM: FSM encoding, wait counter width,
// and bus direction constants.
package gb_bus_pkg;

    localparam int WAIT_CNT_W = 4;

    localparam logic BUS_READ  = 1'b0;
    localparam logic BUS_WRITE = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_t;

endpackage

// File: rtl/bus_wait_ram_if.sv
// Request/response bus between a requester and bus_wait_ram.
// The master drives the request side; the slave returns busy/ready/rdata/err.
interface bus_wait_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, we, addr, wdata,
        input  busy, ready, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, ready, rdata, err
    );
endinterface

// File: rtl/bus_wait_ram_array.sv
// Plain synchronous single-port storage without reset, shaped for block-RAM inference.
// Read data is registered only when i_re is set, so it holds between reads.
module bus_ram_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/bus_wait_ram.sv
// Single-port bus RAM with req/ready handshake and WAIT_STATES programmable stall.
// Optional write protection below PROTECT_TOP when BUS_RAM_WRITE_PROTECT_EN is defined.
module bus_wait_ram
    import gb_bus_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] PROTECT_TOP = 16'h8000
) (
    input  logic           clk,
    input  logic           reset_n,
    bus_wait_ram_if.slave  bus
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("bus_wait_ram: WAIT_STATES must be within 0..15");
    end

    bus_state_t            r_state;
    bus_state_t            w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_cnt_nxt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_ready;
    logic                  r_err;
    logic                  r_rd_seen;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_prot;
    logic                  w_arr_we;
    logic                  w_arr_re;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = WAIT_CNT_W'(WAIT_STATES);
                end
            end
            ST_BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef BUS_RAM_WRITE_PROTECT_EN
    assign w_prot = (r_we == BUS_WRITE) && (r_addr < PROTECT_TOP);
`else
    assign w_prot = 1'b0;
`endif

    // The array is only touched on the completion edge, so a reset while busy
    // leaves a pending write uncommitted.
    assign w_arr_we = w_done && (r_we == BUS_WRITE) && !w_prot;
    assign w_arr_re = w_done && (r_we == BUS_READ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_we      <= BUS_READ;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_rd_seen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_done;
            r_err   <= w_done && w_prot;
            if (w_arr_re) begin
                r_rd_seen <= 1'b1;
            end
            if (w_accept) begin
                r_we    <= bus.we;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
        end
    end

    bus_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    // The array has no reset; mask its output until the first read after reset.
    assign bus.rdata = r_rd_seen ? w_arr_rdata : '0;
    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.ready = r_ready;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_bus_wait_ram.sv
// Scoreboard bench for bus_wait_ram: two instances (0 and 3 wait states), a memory
// reference model, and a monitor that checks every ready pulse against queued expectations.
module tb_bus_wait_ram;
    import gb_bus_pkg::*;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int W0 = 0;
    localparam int W1 = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bus_wait_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    bus_wait_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    bus_wait_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(W0), .PROTECT_TOP(16'h8000))
        dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    bus_wait_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(W1), .PROTECT_TOP(16'h8000))
        dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    logic          req_d   [2];
    logic          we_d    [2];
    logic [AW-1:0] addr_d  [2];
    logic [DW-1:0] wdata_d [2];
    logic          busy_o  [2];
    logic          ready_o [2];
    logic          err_o   [2];
    logic [DW-1:0] rdata_o [2];

    assign bus0.req = req_d[0];   assign bus1.req = req_d[1];
    assign bus0.we = we_d[0];     assign bus1.we = we_d[1];
    assign bus0.addr = addr_d[0]; assign bus1.addr = addr_d[1];
    assign bus0.wdata = wdata_d[0]; assign bus1.wdata = wdata_d[1];
    assign busy_o[0] = bus0.busy;   assign busy_o[1] = bus1.busy;
    assign ready_o[0] = bus0.ready; assign ready_o[1] = bus1.ready;
    assign err_o[0] = bus0.err;     assign err_o[1] = bus1.err;
    assign rdata_o[0] = bus0.rdata; assign rdata_o[1] = bus1.rdata;

    typedef struct {
        bit            is_rd;
        bit            chk;
        logic [DW-1:0] data;
        bit            err;
        int unsigned   cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [DW-1:0] mem_m    [2][0:65535];
    bit            vld_m    [2][0:65535];
    logic [DW-1:0] rd_exp   [2];
    bit            rd_known [2];

    int unsigned cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int n_issued [2] = '{0, 0};
    int n_ready  [2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_prot(input logic we, input logic [AW-1:0] a);
`ifdef BUS_RAM_WRITE_PROTECT_EN
        return we && (a < 16'h8000);
`else
        return 1'b0 && we && (a == '0);
`endif
    endfunction

    // Called at a falling edge; presents one request and returns one cycle later.
    task automatic issue(input int d, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input bit track, output int unsigned acc);
        int unsigned guard;
        exp_t e;
        guard = 0;
        acc = 0;
        while (busy_o[d]) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                check("busy_timeout", 1, 0);
                return;
            end
        end
        req_d[d] = 1'b1; we_d[d] = we; addr_d[d] = a; wdata_d[d] = wd;
        acc = cyc + 1;
        if (track) begin
            e.cyc   = cyc + 2 + ((d == 0) ? W0 : W1);
            e.is_rd = !we;
            e.err   = is_prot(we, a);
            if (we) begin
                e.chk  = rd_known[d];
                e.data = rd_exp[d];
                if (!e.err) begin
                    mem_m[d][a] = wd;
                    vld_m[d][a] = 1'b1;
                end
            end else begin
                e.chk       = vld_m[d][a];
                e.data      = mem_m[d][a];
                rd_known[d] = vld_m[d][a];
                rd_exp[d]   = mem_m[d][a];
            end
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            n_issued[d]++;
        end
        @(negedge clk);
        req_d[d] = 1'b0;
    endtask

    task automatic drain();
        int unsigned guard;
        guard = 0;
        while (q0.size() != 0 || q1.size() != 0 || busy_o[0] || busy_o[1]) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                check("drain_timeout", 1, 0);
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            rd_exp[d]   = '0;
            rd_known[d] = 1'b1;
        end
        q0.delete();
        q1.delete();
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (err_o[d] && !ready_o[d]) check($sformatf("err_without_ready%0d", d), 1, 0);
            if (ready_o[d] === 1'b1) begin
                exp_t e;
                bit have;
                n_ready[d]++;
                have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
                if (!have) begin
                    check($sformatf("unexpected_ready%0d", d), 1, 0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("ready_cycle%0d", d), cyc, e.cyc);
                    check($sformatf("busy_at_ready%0d", d), busy_o[d], 0);
                    check($sformatf("err%0d", d), err_o[d], e.err);
                    if (e.chk) check($sformatf("%s_rdata%0d", e.is_rd ? "rd" : "held", d), rdata_o[d], e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] pool [16];

    initial begin
        int unsigned acc, prev;
        for (int d = 0; d < 2; d++) begin
            req_d[d] = 1'b0; we_d[d] = 1'b0; addr_d[d] = '0; wdata_d[d] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_busy%0d", d), busy_o[d], 0);
            check($sformatf("rst_ready%0d", d), ready_o[d], 0);
            check($sformatf("rst_err%0d", d), err_o[d], 0);
            check($sformatf("rst_rdata%0d", d), rdata_o[d], 0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        // zero-wait write then read
        issue(0, BUS_WRITE, 16'h1000, 8'h88, 1, acc);
        issue(0, BUS_READ, 16'h1000, 8'h00, 1, acc);
        issue(0, BUS_WRITE, 16'hFFFF, 8'hA5, 1, acc);
        issue(0, BUS_READ, 16'hFFFF, 8'h00, 1, acc);
        issue(0, BUS_READ, 16'h1000, 8'h00, 1, acc);
        drain();

        // three-wait read with an ignored request pulse while busy
        issue(1, BUS_WRITE, 16'hFF80, 8'hFC, 1, acc);
        issue(1, BUS_READ, 16'hFF80, 8'h00, 1, acc);
        check("busy_after_accept", busy_o[1], 1);
        req_d[1] = 1'b1; we_d[1] = BUS_WRITE; addr_d[1] = 16'hFF80; wdata_d[1] = 8'h00;
        @(negedge clk);
        req_d[1] = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        // back-to-back writes on both instances, spacing WAIT_STATES+2
        for (int d = 0; d < 2; d++) begin
            prev = 0;
            for (int i = 0; i < 5; i++) begin
                issue(d, BUS_WRITE, 16'hFF10 + AW'(i), 8'h12, 1, acc);
                if (i > 0) check($sformatf("b2b_spacing%0d", d), acc - prev, ((d == 0) ? W0 : W1) + 2);
                prev = acc;
            end
            for (int i = 0; i < 5; i++) issue(d, BUS_READ, 16'hFF10 + AW'(i), 8'h00, 1, acc);
        end
        drain();

        // async reset with req held on one instance and the other mid-access
        issue(1, BUS_READ, 16'hFF80, 8'h00, 0, acc);
        req_d[0] = 1'b1; we_d[0] = BUS_READ; addr_d[0] = 16'h1000;
        #2;
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("async_busy%0d", d), busy_o[d], 0);
            check($sformatf("async_ready%0d", d), ready_o[d], 0);
            check($sformatf("async_err%0d", d), err_o[d], 0);
            check($sformatf("async_rdata%0d", d), rdata_o[d], 0);
        end
        @(negedge clk);
        req_d[0] = 1'b0;
        model_reset();
        reset_n = 1'b1;
        @(negedge clk);

        // pending write aborted by reset must not commit
        issue(1, BUS_WRITE, 16'hFF20, 8'h3C, 1, acc);
        drain();
        issue(1, BUS_WRITE, 16'hFF20, 8'hF0, 0, acc);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        issue(1, BUS_READ, 16'hFF20, 8'h00, 1, acc);
        drain();

`ifdef BUS_RAM_WRITE_PROTECT_EN
        issue(1, BUS_WRITE, 16'h0100, 8'h55, 1, acc);
        issue(1, BUS_WRITE, 16'hC000, 8'h55, 1, acc);
        issue(1, BUS_READ, 16'hC000, 8'h00, 1, acc);
        issue(0, BUS_WRITE, 16'h7FFF, 8'h55, 1, acc);
        issue(0, BUS_WRITE, 16'h8000, 8'h66, 1, acc);
        issue(0, BUS_READ, 16'h8000, 8'h00, 1, acc);
        drain();
`endif

        // randomized traffic over a small address pool including boundary addresses
        pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h7FFF; pool[3] = 16'h8000;
        for (int i = 4; i < 16; i++) pool[i] = AW'($urandom_range(0, 65535));
        for (int i = 0; i < 80; i++) begin
            int d;
            logic w;
            d = int'($urandom_range(0, 1));
            w = logic'($urandom_range(0, 1));
            issue(d, w, pool[$urandom_range(0, 15)], DW'($urandom_range(0, 255)), 1, acc);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        for (int d = 0; d < 2; d++) check($sformatf("ready_count%0d", d), n_ready[d], n_issued[d]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
